// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Synchronizes, debounces and parity-tags a bank of raw GPIO input pins
//   for consumption by a GPIO slave.
//
//   Parameters
//     DATA_W     number of conditioned pins
//     DB_CNT     consecutive stable synchronized cycles needed to accept a
//                new pin level (1..255)
//
//   Ports
//     HCLK       system clock, all state on rising edge
//     HRESETn    asynchronous active-low reset
//     PINS       raw pin levels, asynchronous to HCLK
//     PARITYSEL  parity mode, 0 = even, 1 = odd (synchronous to HCLK)
//     GPIOIN     {parity, debounced data[DATA_W-1:0]}, registered
//     CHANGED    one-cycle strobe in the first cycle of a new data value
module gpio_in_conditioner #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DB_CNT = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [DATA_W-1:0] PINS,
  input  logic              PARITYSEL,
  output logic [DATA_W:0]   GPIOIN,
  output logic              CHANGED
);

  localparam int unsigned CNT_W = 8;
  // Terminal count: the edge at which the counter sits here and s2 still
  // differs from deb is the DB_CNT-th stable cycle.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

  logic [DATA_W-1:0]            s1_q, s1_d;
  logic [DATA_W-1:0]            s2_q, s2_d;
  logic [DATA_W-1:0]            deb_q, deb_d;
  logic [DATA_W-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                         par_q, par_d;
  logic                         changed_q, changed_d;

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_comb begin
    s1_d = PINS;
    s2_d = s1_q;
  end

  // Per-bit stability counter; a bit that returns to its debounced level
  // clears only its own counter, so the counter can never pass CNT_MAX.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Parity and change strobe are taken from the next debounced value so
  // they land on the same edge as the data bits.
  always_comb begin
    par_d     = (^deb_d) ^ PARITYSEL;
    changed_d = (deb_d != deb_q);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      changed_q <= changed_d;
    end
  end

  assign GPIOIN  = {par_q, deb_q};
  assign CHANGED = changed_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner
//   Bench for gpio_in_conditioner (DATA_W=16, DB_CNT=4). A behavioural
//   reference of the synchronizer/debounce rule predicts each cycle's
//   output; predictions are queued before the edge and compared after it.
//   Directed checks cover latency, pulse rejection, parity mode, reset.
module tb_gpio_in_conditioner;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DB_CNT = 4;

  logic              HCLK;
  logic              HRESETn;
  logic [DATA_W-1:0] PINS;
  logic              PARITYSEL;
  logic [DATA_W:0]   GPIOIN;
  logic              CHANGED;

  gpio_in_conditioner #(.DATA_W(DATA_W), .DB_CNT(DB_CNT)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .PINS     (PINS),
    .PARITYSEL(PARITYSEL),
    .GPIOIN   (GPIOIN),
    .CHANGED  (CHANGED)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [DATA_W:0] g;
    logic            c;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic [DATA_W-1:0] m_s1, m_s2, m_deb;
  int                m_cnt [DATA_W];
  logic              m_par, m_chg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1  = '0;
    m_s2  = '0;
    m_deb = '0;
    m_par = 1'b0;
    m_chg = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [DATA_W-1:0] pins, input logic psel);
    logic [DATA_W-1:0] nd;
    nd = m_deb;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (m_s2[i] == m_deb[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] == int'(DB_CNT) - 1) begin
        nd[i]    = m_s2[i];
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_chg = (nd != m_deb);
    m_par = (^nd) ^ psel;
    m_deb = nd;
    m_s2  = m_s1;
    m_s1  = pins;
  endtask

  // One clock: predict, queue, advance, then pop and compare.
  task automatic tick();
    exp_t e;
    if (!HRESETn) begin
      model_reset();
      e = '0;
    end else begin
      model_step(PINS, PARITYSEL);
      e.g = {m_par, m_deb};
      e.c = m_chg;
    end
    sb_q.push_back(e);
    @(posedge HCLK);
    #1;
    e = sb_q.pop_front();
    chk("sb_gpioin", 32'(GPIOIN), 32'(e.g));
    chk("sb_changed", 32'(CHANGED), 32'(e.c));
  endtask

  int nchg;
  int nhi;
  int cyc;
  int hold;

  initial begin
    HRESETn   = 1'b0;
    PINS      = '0;
    PARITYSEL = 1'b0;
    model_reset();
    #2;
    chk("rst_gpioin", 32'(GPIOIN), 32'h0);
    chk("rst_changed", 32'(CHANGED), 32'h0);
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (3) tick();

    // 0x0000 -> 0x00A5: visible exactly after the 6th edge
    PINS = 16'h00A5;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("a5_wait", 32'(GPIOIN), 32'h0);
      chk("a5_wait_chg", 32'(CHANGED), 32'h0);
    end
    tick();
    chk("a5_value", 32'(GPIOIN), 32'h000A5);
    chk("a5_chg", 32'(CHANGED), 32'h1);
    tick();
    chk("a5_chg_once", 32'(CHANGED), 32'h0);
    repeat (3) tick();

    // 3-cycle pulse on bit 3 is rejected
    PINS = 16'h00AD;
    repeat (3) tick();
    PINS = 16'h00A5;
    nchg = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      nchg += int'(CHANGED);
      chk("p3_gpioin", 32'(GPIOIN), 32'h000A5);
    end
    chk("p3_nchg", 32'(nchg), 32'd0);

    // 4-cycle pulse propagates: 4 cycles high, two strobes
    PINS = 16'h00AD;
    repeat (4) tick();
    PINS = 16'h00A5;
    nchg = 0;
    nhi  = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      nchg += int'(CHANGED);
      nhi  += int'(GPIOIN[3]);
      if (GPIOIN[3]) chk("p4_value", 32'(GPIOIN), 32'h100AD);
    end
    chk("p4_nchg", 32'(nchg), 32'd2);
    chk("p4_hi", 32'(nhi), 32'd4);

    // Parity mode switch alone flips only the parity bit
    PINS = 16'h0001;
    repeat (8) tick();
    chk("ps_pre", 32'(GPIOIN), 32'h10001);
    PARITYSEL = 1'b1;
    tick();
    chk("ps_post", 32'(GPIOIN), 32'h00001);
    chk("ps_chg", 32'(CHANGED), 32'h0);

    // Reset mid-count discards progress; full latency after release
    PARITYSEL = 1'b0;
    tick();
    PINS = 16'hFFFF;
    repeat (4) tick();
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_gpioin", 32'(GPIOIN), 32'h0);
    chk("rst_mid_chg", 32'(CHANGED), 32'h0);
    repeat (2) tick();
    HRESETn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ff_wait", 32'(GPIOIN), 32'h0);
    end
    tick();
    chk("ff_value", 32'(GPIOIN), 32'h0FFFF);
    chk("ff_chg", 32'(CHANGED), 32'h1);

    // Odd mode: parity correct on first edge after release
    HRESETn = 1'b0;
    model_reset();
    PARITYSEL = 1'b1;
    PINS = '0;
    #1;
    tick();
    HRESETn = 1'b1;
    tick();
    chk("odd_first", 32'(GPIOIN), 32'h10000);

    // Random pin activity in odd mode
    cyc = 0;
    while (cyc < 10000) begin
      PINS = PINS ^ 16'($urandom & $urandom & $urandom);
      hold = int'($urandom_range(1, 10));
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("odd_parity", 32'(^GPIOIN), 32'h1);
        cyc++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter: DATA_W, 16, number of conditioned input pins.
REQ-002 Parameter: DB_CNT, 4, consecutive stable cycles needed to accept a new pin level (legal range 1..255).
REQ-003 Port: HCLK  input  1  system clock, all state on rising edge.
REQ-004 Port: HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: PINS  input  DATA_W  raw external pin levels, asynchronous to HCLK.
REQ-006 Port: PARITYSEL  input  1  parity mode (0 = even, 1 = odd), synchronous to HCLK.
REQ-007 Port: GPIOIN  output  DATA_W+1  conditioned word for the GPIO slave; [DATA_W-1:0] debounced data, [DATA_W] parity bit.
REQ-008 Port: CHANGED  output  1  single-cycle strobe, high in the cycle GPIOIN data bits take a new value.

Function
REQ-009 Each PINS bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-010 Each bit SHALL own an 8-bit stability counter cnt and a debounced register deb.
REQ-011 Per bit, per edge: if s2 == deb then cnt <= 0; else if cnt == DB_CNT-1 then deb <= s2 and cnt <= 0; else cnt <= cnt+1.
REQ-012 A pin change first sampled by s1 at edge E0 SHALL appear on GPIOIN at edge E0+DB_CNT+1 (DB_CNT=4: visible after the 6th edge, E0..E5).
REQ-013 A pin pulse shorter than DB_CNT synchronized cycles SHALL be rejected (counter clears, deb unchanged); a pulse of DB_CNT or more cycles SHALL propagate.
REQ-014 Bits SHALL debounce independently; simultaneous changes on several bits with equal stability SHALL update GPIOIN in the same cycle.
REQ-015 GPIOIN[DATA_W] SHALL be registered every edge as XOR-reduce(next deb) XOR PARITYSEL, so data and parity change on the same edge with no skew.
REQ-016 Even mode: total ones in GPIOIN even; odd mode: total ones odd.
REQ-017 A PARITYSEL change SHALL update the parity bit on the next edge without altering data bits or asserting CHANGED.
REQ-018 CHANGED SHALL be registered and high for exactly one cycle, coincident with the first cycle of any new GPIOIN data value; back-to-back updates on consecutive edges give CHANGED high in each.
REQ-019 A bit toggling back to deb mid-count SHALL clear only that bit's counter; other bits' counters are unaffected.
REQ-020 DB_CNT=1 SHALL update deb on the first edge at which s2 != deb.
REQ-021 Counter SHALL never exceed DB_CNT-1 and never wrap.

Reset
REQ-022 HRESETn low SHALL immediately clear s1, s2, deb, all cnt, GPIOIN (all bits including parity) and CHANGED to 0.
REQ-023 After HRESETn release the parity bit SHALL be correct on the first edge (odd mode: GPIOIN[DATA_W] = 1 after first edge).
REQ-024 Reset asserted mid-count SHALL discard partial counts; after release, a pin held at 1 requires the full DB_CNT+2 edges to appear.
REQ-025 Pins held nonzero through reset SHALL be treated as a fresh change after release; no CHANGED pulse during reset.

Verification
REQ-026 DB_CNT=4, PARITYSEL=0, PINS 0x0000 -> 0x00A5 held -> GPIOIN = 0x000A5 exactly 6 edges after first sample, parity 0, CHANGED one cycle.
REQ-027 PINS bit 3 pulsed high for 3 cycles, then 4 cycles -> 3-cycle pulse: GPIOIN unchanged, no CHANGED; 4-cycle pulse: bit 3 set for 4 cycles then cleared, two CHANGED strobes.
REQ-028 deb = 0x0001, PARITYSEL 0 -> 1 -> GPIOIN[16] 1 -> 0 on next edge, data 0x0001 unchanged, CHANGED stays 0.
REQ-029 PINS 0xFFFF held, HRESETn pulsed low at count 2 -> GPIOIN 0x00000 immediately; after release 0xFFFF reappears after full 6 edges, parity 0.
REQ-030 PARITYSEL=1, random PINS with hold times 1..10 cycles for 10k cycles -> GPIOIN always odd parity; every accepted value matches a reference model of REQ-011.
